// File: rtl/acc_icb_sram_pkg.sv
// Shared accelerator ICB definitions: bus field widths and the response FIFO entry.
package acc_icb_sram_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_entry_t;

endpackage

// File: rtl/acc_rsp_fifo.sv
// Two-entry in-order response FIFO; push while full is only honoured alongside a pop.
module acc_rsp_fifo
  import acc_icb_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  rsp_entry_t din,
  output rsp_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  rsp_entry_t slot [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= din;
  end

  assign dout  = slot[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/acc_icb_sram.sv
// ICB-attached word SRAM with byte-masked writes and a 2-deep response FIFO.
// Define ACC_ICB_SRAM_RANGE_CHK_EN to flag out-of-window or misaligned commands.
module acc_icb_sram
  import acc_icb_sram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h1000_0000,
  parameter int                DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic [DATA_W-1:0] icb_cmd_wdata,
  input  logic [MASK_W-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DATA_W-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              cmd_fire;
  logic              cmd_err;
  logic [DATA_W-1:0] wr_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  rsp_entry_t        rsp_in;
  rsp_entry_t        rsp_head;
  logic              unused_off;

  assign offset     = icb_cmd_addr - ADDR_BASE;
  assign idx        = offset[IDX_W+1:2];
  assign unused_off = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};

`ifdef ACC_ICB_SRAM_RANGE_CHK_EN
  // An address below the base wraps the offset high, so one compare covers both ends.
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  assign cmd_err = ({1'b0, offset} >= SPAN) || (icb_cmd_addr[1:0] != 2'b00);
`else
  assign cmd_err = 1'b0;
`endif

  // Readiness looks only at registered occupancy, so a pop frees a slot next cycle.
  assign icb_cmd_ready = !rst && !fifo_full;
  assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;

  always_comb begin
    wr_word = mem[idx];
    for (int b = 0; b < MASK_W; b++) begin
      if (icb_cmd_wmask[b]) wr_word[8*b +: 8] = icb_cmd_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && !icb_cmd_read && !cmd_err) mem[idx] <= wr_word;
  end

  // Read data is captured into the FIFO at the handshake edge: response visible at T+1.
  always_comb begin
    rsp_in.err   = cmd_err;
    rsp_in.rdata = (icb_cmd_read && !cmd_err) ? mem[idx] : '0;
  end

  acc_rsp_fifo u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_fire),
    .pop   (icb_rsp_ready),
    .din   (rsp_in),
    .dout  (rsp_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign icb_rsp_valid = (fifo_count != 2'd0);
  assign icb_rsp_rdata = fifo_empty ? '0 : rsp_head.rdata;
  assign icb_rsp_err   = fifo_empty ? 1'b0 : rsp_head.err;

endmodule

// File: tb/tb_acc_icb_sram.sv
// Bench for acc_icb_sram: vector table, corner sequences and a randomized run against a word-array model.
`timescale 1ns/1ps
module tb_acc_icb_sram;
  import acc_icb_sram_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
`ifdef ACC_ICB_SRAM_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  acc_icb_sram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (cmd_ready),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_rdata (rsp_rdata),
    .icb_rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_data;
  } exp_t;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];
  bit          last_cf;
  bit          last_pf;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
    longint unsigned lo;
    longint unsigned hi;
    lo = longint'(BASE);
    hi = longint'(BASE) + 4 * DEPTH;
    if (!RANGE_CHK) return 1'b0;
    return (longint'(a) < lo) || (longint'(a) >= hi) || (a % 4 != 0);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  // One clock: judge the handshakes that the coming edge will take, then advance.
  task automatic tick();
    last_cf = cmd_valid && cmd_ready;
    last_pf = rsp_valid && rsp_ready;
    if (last_pf) begin
      exp_t e;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", rsp_err, e.err);
        if (e.chk_data) check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
    if (last_cf) begin
      exp_t e;
      int   i;
      e.err      = model_err(cmd_addr);
      e.rdata    = 32'h0;
      e.chk_data = 1'b1;
      i = model_idx(cmd_addr);
      if (!e.err) begin
        if (cmd_read) begin
          e.rdata    = mem_m[i];
          e.chk_data = known[i];
        end else begin
          for (int b = 0; b < 4; b++)
            if (cmd_wmask[b]) mem_m[i][8*b +: 8] = cmd_wdata[8*b +: 8];
          if (cmd_wmask == 4'hF) known[i] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_txn(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = m;
    rsp_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!last_cf && n < 20);
    cmd_valid = 1'b0;
    check("txn_accept", 32'(last_cf), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    lat = n + 1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("txn_rsp", 32'(last_pf), 32'd1);
    rdata = last_rdata;
    err   = last_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [11];
    logic [31:0] r;
    logic        e;
    int          lat;
    int          acc;
    int          got;
    int          n;
    int          issued;
    int          pops;
    bit          have_hold;
    bit          stable_bad;
    logic [31:0] hold_rdata;
    logic [31:0] popped [4];

    vt[0]  = '{1'b0, BASE + 32'h8,  32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0};
    vt[1]  = '{1'b1, BASE + 32'h8,  32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b0, BASE + 32'h10, 32'h1122_3344, 4'hF,    32'h0,         1'b0};
    vt[3]  = '{1'b0, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
    vt[4]  = '{1'b1, BASE + 32'h10, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
    vt[5]  = '{1'b0, BASE + 32'h10, 32'h1234_5678, 4'h0,    32'h0,         1'b0};
    vt[6]  = '{1'b1, BASE + 32'h10, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
    vt[7]  = '{1'b0, BASE + 32'hFFC, 32'hCAFE_0001, 4'hF,   32'h0,         1'b0};
    vt[8]  = '{1'b1, BASE + 32'hFFC, 32'h0,        4'h0,    32'hCAFE_0001, 1'b0};
    vt[9]  = '{1'b0, BASE,          32'h55AA_55AA, 4'hF,    32'h0,         1'b0};
    vt[10] = '{1'b1, BASE,          32'h0,         4'h0,    32'h55AA_55AA, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wmask = 4'h0; rsp_ready = 1'b0;
    last_cf = 1'b0; last_pf = 1'b0; last_rdata = 32'h0; last_err = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Vector table
    for (int k = 0; k < 11; k++) begin
      do_txn(vt[k].rd, vt[k].addr, vt[k].wdata, vt[k].mask, r, e, lat);
      check($sformatf("vec%0d_rdata", k), r, vt[k].exp_rdata);
      check($sformatf("vec%0d_err", k), 32'(e), 32'(vt[k].exp_err));
      check($sformatf("vec%0d_lat", k), lat, 32'd1);
    end

    // Range / alignment handling
    do_txn(1'b0, BASE + 4 * DEPTH, 32'hFFFF_0000, 4'hF, r, e, lat);
    check("range_wr_err", 32'(e), RANGE_CHK ? 32'd1 : 32'd0);
    do_txn(1'b1, BASE, 32'h0, 4'h0, r, e, lat);
    check("range_word0", r, RANGE_CHK ? 32'h55AA_55AA : 32'hFFFF_0000);
    do_txn(1'b1, BASE + 32'h9, 32'h0, 4'h0, r, e, lat);
    check("misalign_err", 32'(e), RANGE_CHK ? 32'd1 : 32'd0);
    check("misalign_rdata", r, RANGE_CHK ? 32'h0 : 32'hDEAD_BEEF);
    do_txn(1'b1, BASE - 32'h4, 32'h0, 4'h0, r, e, lat);
    check("below_base_err", 32'(e), RANGE_CHK ? 32'd1 : 32'd0);
    check("below_base_rdata", r, RANGE_CHK ? 32'h0 : 32'hCAFE_0001);

    // Backpressure: only two reads fit while responses are stalled
    for (int k = 0; k < 4; k++)
      do_txn(1'b0, BASE + 4 * (20 + k), 32'hB0B0_0000 + k, 4'hF, r, e, lat);
    rsp_ready = 1'b0; acc = 0; have_hold = 1'b0; stable_bad = 1'b0; hold_rdata = 32'h0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 4 * (20 + acc);
      if (rsp_valid && !have_hold) begin
        have_hold = 1'b1; hold_rdata = rsp_rdata;
      end else if (have_hold && (!rsp_valid || rsp_rdata !== hold_rdata || rsp_err !== 1'b0)) begin
        stable_bad = 1'b1;
      end
      tick();
      if (last_cf) acc++;
    end
    check("bp_accepted", acc, 32'd2);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_stable", 32'(stable_bad), 32'd0);
    check("bp_head", hold_rdata, 32'hB0B0_0000);
    rsp_ready = 1'b1; got = 0; n = 0;
    while ((got < 4 || acc < 4) && n < 20) begin
      cmd_valid = (acc < 4); cmd_addr = BASE + 4 * (20 + acc);
      tick();
      if (last_cf) acc++;
      if (last_pf && got < 4) begin popped[got] = last_rdata; got++; end
      n++;
    end
    cmd_valid = 1'b0;
    check("bp_rsp_count", got, 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("bp_order%0d", k), popped[k], 32'hB0B0_0000 + k);

    // Throughput: 16 back-to-back reads
    issued = 0; pops = 0;
    for (int c = 0; c < 17; c++) begin
      cmd_valid = (issued < 16); cmd_read = 1'b1; cmd_addr = BASE + 4 * (20 + issued % 4);
      tick();
      if (last_cf) issued++;
      if (last_pf) pops++;
      if (c == 15) check("tp_hs_by16", issued, 32'd16);
    end
    cmd_valid = 1'b0;
    check("tp_rsp", pops, 32'd16);

    // Reset with two responses pending
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 4 * 21;
    tick(); tick();
    cmd_valid = 1'b0;
    check("mid_pending", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_post_ready", 32'(cmd_ready), 32'd1);
    check("mid_post_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    do_txn(1'b1, BASE + 4 * 22, 32'h0, 4'h0, r, e, lat);
    check("mid_after_read", r, 32'hB0B0_0002);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int sel;
      int w;
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_read  = $urandom_range(0, 1);
      if (sel < 8)       cmd_addr = BASE + 4 * w;
      else if (sel == 8) cmd_addr = BASE + 4 * DEPTH + 4 * w;
      else               cmd_addr = BASE + 4 * w + $urandom_range(1, 3);
      cmd_wdata = $urandom;
      cmd_wmask = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
